// File: rtl/counter_seek_ctrl.sv
// rtl/counter_seek_ctrl.sv - shortest-path seek sequencer driving a modulo-N up/down counter
// Optional abort input is enabled by defining COUNTER_SEEK_ABORT_EN.
module counter_seek_ctrl #(
  parameter int X        = 2,
  parameter int N        = 3,
  parameter int STEP_DIV = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  input  logic [X-1:0] req_target,
  output logic         req_ready,
  input  logic [X-1:0] cur_count,
  output logic         cnt_enable,
  output logic         cnt_updown,
  output logic         busy,
  output logic         done,
  output logic         err
`ifdef COUNTER_SEEK_ABORT_EN
  ,
  input  logic         abort
`endif
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SL = STEP_DIV - 1;
  localparam logic [X:0]    NW          = N[X:0];
  localparam logic [SW-1:0] SETTLE_LAST = SL[SW-1:0];

  typedef enum logic [2:0] {S_IDLE, S_PLAN, S_STEP, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [X-1:0]  tgt_q, tgt_d;
  logic [X:0]    step_q, step_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          dir_q, dir_d;
  logic          en_q, done_q, err_q, err_d;
  logic [X:0]    up_dist, down_dist;
  logic          abort_hit;

`ifdef COUNTER_SEEK_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Distance going up around the ring; the down distance is its complement to N.
  always_comb begin
    if (tgt_q >= cur_count)
      up_dist = {1'b0, tgt_q} - {1'b0, cur_count};
    else
      up_dist = {1'b0, tgt_q} + NW - {1'b0, cur_count};
    down_dist = NW - up_dist;
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    settle_d = settle_q;
    dir_d    = dir_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if ({1'b0, req_target} >= NW) begin
            err_d = 1'b1;
          end else begin
            tgt_d   = req_target;
            state_d = S_PLAN;
          end
        end
      end
      S_PLAN: begin
        step_d = '0;
        if (up_dist == '0) begin
          state_d = S_DONE;
        end else begin
          dir_d   = (up_dist > down_dist);
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        step_d   = step_q + 1'b1;
        settle_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SETTLE_LAST) begin
          if (cur_count == tgt_q) begin
            state_d = S_DONE;
          end else if (step_q == NW) begin
            // N steps without reaching the target: the counter is not following
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit && (state_q == S_PLAN || state_q == S_STEP || state_q == S_WAIT)) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      step_q   <= '0;
      settle_q <= '0;
      dir_q    <= 1'b0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      dir_q    <= dir_d;
      en_q     <= (state_d == S_STEP);
      done_q   <= (state_d == S_DONE);
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign cnt_enable = en_q;
  assign cnt_updown = dir_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_counter_seek_ctrl.sv
// tb/tb_counter_seek_ctrl.sv - self-checking bench for counter_seek_ctrl with a modelled mod-N counter
module tb_counter_seek_ctrl;
  localparam int X  = 3;
  localparam int N  = 6;
  localparam int SD = 2;
  localparam int MAXC = 4096;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [X-1:0] req_target = '0;
  logic         req_ready, cnt_enable, cnt_updown, busy, done, err;
  logic [X-1:0] cur_count;
`ifdef COUNTER_SEEK_ABORT_EN
  logic         abort = 1'b0;
`endif

  counter_seek_ctrl #(.X(X), .N(N), .STEP_DIV(SD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .cur_count  (cur_count),
    .cnt_enable (cnt_enable),
    .cnt_updown (cnt_updown),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef COUNTER_SEEK_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Driven mod-N counter; frz models a counter that ignores its enable.
  logic         ld = 1'b0, frz = 1'b0;
  logic [X-1:0] ld_val = '0, cnt = '0;
  always @(posedge clk) begin
    if (ld)
      cnt <= ld_val;
    else if (cnt_enable && !frz)
      cnt <= cnt_updown ? ((cnt == 0) ? X'(N - 1) : cnt - 1'b1)
                        : ((cnt == X'(N - 1)) ? '0 : cnt + 1'b1);
  end
  assign cur_count = cnt;

  int n_total = 0;
  int n_pass  = 0;
  int npulse  = 0;

  bit e_en   [MAXC];
  bit e_dir  [MAXC];
  bit e_busy [MAXC];
  bit e_done [MAXC];
  bit e_err  [MAXC];

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_en[i] = 0; e_dir[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
    end
  endtask

  // Expected timeline of one seek whose PLAN cycle is c0; td = cycles from PLAN to the ending pulse.
  task automatic plan(input int c0, input int tgt, input int cur, input bit frozen,
                      output int d, output int td);
    int up, dn, steps, endc;
    bit dir;
    if (tgt >= N) begin
      e_err[c0] = 1;
      d = 0;
      td = -1;
      return;
    end
    up  = (tgt - cur + N) % N;
    dn  = (N - up) % N;
    dir = (dn < up);
    d   = dir ? dn : up;
    steps = (frozen && d != 0) ? N : d;
    for (int k = 0; k < steps; k++) begin
      e_en[c0 + 1 + k * (1 + SD)]  = 1;
      e_dir[c0 + 1 + k * (1 + SD)] = dir;
    end
    endc = c0 + 1 + steps * (1 + SD);
    for (int c = c0; c < endc; c++) e_busy[c] = 1;
    if (frozen && d != 0) begin
      e_err[endc] = 1;
    end else begin
      e_done[endc] = 1;
      e_busy[endc] = 1;
    end
    td = endc - c0;
  endtask

  always @(negedge clk) begin
    logic [5:0] expv, actv;
    if (cyc < MAXC) begin
      expv = {~e_busy[cyc], e_busy[cyc], e_en[cyc], e_en[cyc] & e_dir[cyc], e_done[cyc], e_err[cyc]};
      actv = {req_ready, busy, cnt_enable, cnt_enable & cnt_updown, done, err};
      check("outputs{ready,busy,en,dn,done,err}", int'(actv), int'(expv));
    end
    if (cnt_enable) npulse++;
  end

  task automatic load(input int v);
    @(negedge clk);
    ld = 1'b1;
    ld_val = X'(v);
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic seek(input int tgt, input bit frozen, input bit wait_end,
                      output int c0, output int d, output int td);
    @(negedge clk);
    check("req_ready before request", int'(req_ready), 1);
    c0 = cyc + 1;
    plan(c0, tgt, int'(cur_count), frozen, d, td);
    req_valid  = 1'b1;
    req_target = X'(tgt);
    @(negedge clk);
    req_valid = 1'b0;
    if (wait_end) repeat (((td < 0) ? 0 : td) + 3) @(negedge clk);
  endtask

  initial begin
    int c0, d, td, p0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 1: tie resolves upward
    load(1); p0 = npulse;
    seek(4, 0, 1, c0, d, td);
    check("t1 steps", d, 3);
    check("t1 plan-to-done", td, 10);
    check("t1 pulses", npulse - p0, 3);
    check("t1 final count", int'(cur_count), 4);

    // 2: shorter path is down
    load(1); p0 = npulse;
    seek(5, 0, 1, c0, d, td);
    check("t2 steps", d, 2);
    check("t2 pulses", npulse - p0, 2);
    check("t2 final count", int'(cur_count), 5);

    // 3: wrap-around both ways
    load(0); p0 = npulse;
    seek(5, 0, 1, c0, d, td);
    check("t3a pulses", npulse - p0, 1);
    check("t3a final count", int'(cur_count), 5);
    p0 = npulse;
    seek(0, 0, 1, c0, d, td);
    check("t3b pulses", npulse - p0, 1);
    check("t3b final count", int'(cur_count), 0);

    // 4: already at target, then out-of-range target
    load(3); p0 = npulse;
    seek(3, 0, 1, c0, d, td);
    check("t4a plan-to-done", td, 1);
    check("t4a pulses", npulse - p0, 0);
    p0 = npulse;
    seek(7, 0, 1, c0, d, td);
    check("t4b pulses", npulse - p0, 0);
    check("t4b ready after err", int'(req_ready), 1);

    // 5: counter not following trips the step guard
    load(2); frz = 1'b1; p0 = npulse;
    seek(5, 1, 1, c0, d, td);
    frz = 1'b0;
    check("t5 pulses", npulse - p0, 6);
    check("t5 plan-to-err", td, 19);
    check("t5 count unchanged", int'(cur_count), 2);

    // 5b: asynchronous reset in the middle of WAIT
    load(0);
    seek(3, 0, 0, c0, d, td);
    while (cyc < c0 + 2) @(negedge clk);
    #2 reset_n = 1'b0;
    clear_from(cyc);
    #1;
    check("rst busy", int'(busy), 0);
    check("rst ready", int'(req_ready), 1);
    check("rst outputs{en,dn,done,err}", int'({cnt_enable, cnt_updown, done, err}), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

`ifdef COUNTER_SEEK_ABORT_EN
    // 6: abort during the second settle interval
    load(0); p0 = npulse;
    seek(3, 0, 0, c0, d, td);
    while (cyc < c0 + 5) @(negedge clk);
    abort = 1'b1;
    clear_from(c0 + 6);
    @(negedge clk);
    abort = 1'b0;
    repeat (12) @(negedge clk);
    check("t6 pulses", npulse - p0, 2);
    check("t6 final count", int'(cur_count), 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
